// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encoding and the byte order of words inside the program image.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    RUN    = 3'd4,
    ERROR  = 3'd5
  } state_t;

  // Image words arrive most-significant byte first.
  localparam bit IMG_MSB_FIRST = 1'b1;

endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Packs accepted bytes into 32-bit words. word_valid/word are combinational
// on the cycle the 4th byte is presented, so the owner can register the
// write strobe and land it exactly one cycle after the accept edge.
module byte_word_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] sh;
  logic [1:0]  cnt;

  assign word_valid = byte_valid && (cnt == 2'd3);
  assign word = IMG_MSB_FIRST ? {sh, byte_in}
                              : {byte_in, sh[7:0], sh[15:8], sh[23:16]};

  // Shift in each byte and count position within the current word.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh  <= '0;
      cnt <= '0;
    end else if (byte_valid) begin
      sh  <= {sh[15:0], byte_in};
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed program image
// as a byte stream, writes it into instruction memory from word 0 upwards,
// and releases the CPU reset only once the checksum matches.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);

  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

  state_t          state;
  logic [7:0]      len_hi;
  logic [15:0]     n_words;
  logic [ADDR_W:0] wcnt;      // one extra bit so N = MAX_WORDS is representable
  logic [7:0]      xacc;

  logic        acc;
  logic        pk_valid;
  logic        word_valid;
  logic [31:0] word;
  logic [15:0] len;
  logic        oversize;
  logic        last_word;

  // Ready is a pure state decode; the stream is never stalled mid-image.
  assign rx_ready  = (state == LEN_HI) || (state == LEN_LO) ||
                     (state == DATA)   || (state == CSUM);
  assign acc       = rx_valid && rx_ready;
  assign pk_valid  = acc && (state == DATA);
  assign len       = {len_hi, rx_data};
  assign oversize  = 32'(len) > MAX_WORDS;
  assign last_word = (32'(wcnt) + 32'd1) == 32'(n_words);

  byte_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (pk_valid),
    .byte_in    (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Loader FSM plus address counter, running XOR and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LEN_HI;
      len_hi     <= '0;
      n_words    <= '0;
      wcnt       <= '0;
      xacc       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (word_valid) begin
        imem_we    <= 1'b1;
        imem_addr  <= wcnt[ADDR_W-1:0];
        imem_wdata <= word;
        wcnt       <= wcnt + (ADDR_W+1)'(1);
      end
      // The checksum byte itself is excluded from the running XOR.
      if (acc && (state != CSUM)) xacc <= xacc ^ rx_data;
      if (acc) begin
        case (state)
          LEN_HI: begin
            len_hi <= rx_data;
            state  <= LEN_LO;
          end
          LEN_LO: begin
            n_words <= len;
            if (oversize) begin
              state      <= ERROR;
              load_error <= 1'b1;
            end else if (len == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            if (word_valid && last_word) state <= CSUM;
          end
          CSUM: begin
            if (rx_data == xacc) begin
              state     <= RUN;
              cpu_reset <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: drives images byte by byte, pushes expected
// writes (address, data, due cycle) to a scoreboard, and pops them when
// the DUT strobes imem_we.
module tb_imem_boot_loader;

  localparam int ADDR_W = 8;
  localparam int MAXW   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              load_done;
  logic              load_error;

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                due;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write,
  // arriving exactly on its due cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexp_we", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e.addr));
        chk("wr_data", imem_wdata, e.data);
        chk("wr_lat", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic pulse_reset();
    rx_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_error), 32'd0);
    chk("rst_ready", 32'(rx_ready), 32'd1);
  endtask

  task automatic drive_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // csum_arg < 0 means "use the correct checksum"; abort_at > 0 pulses
  // reset right after that many bytes have been sent.
  task automatic load_image(input logic [31:0] w[$], input int n, input int csum_arg,
                            input int maxgap, input int abort_at);
    logic [7:0]  b[$];
    logic [7:0]  x;
    logic [7:0]  cs;
    logic [15:0] nn;
    logic [31:0] wd;
    bit          over;
    bit          ok;
    nn = 16'(n);
    b.push_back(nn[15:8]);
    b.push_back(nn[7:0]);
    foreach (w[k]) begin
      wd = w[k];
      b.push_back(wd[31:24]);
      b.push_back(wd[23:16]);
      b.push_back(wd[15:8]);
      b.push_back(wd[7:0]);
    end
    x = 8'h00;
    foreach (b[i]) x = x ^ b[i];
    cs = (csum_arg < 0) ? x : 8'(csum_arg);
    b.push_back(cs);
    over = (n > MAXW);
    for (int i = 0; i < b.size(); i++) begin
      if (over && i >= 2) break;
      drive_byte(b[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      if (i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3)
        sb.push_back('{addr: ADDR_W'((i - 2) / 4), data: w[(i - 2) / 4], due: cyc});
      if (abort_at > 0 && i + 1 == abort_at) begin
        pulse_reset();
        chk("abort_sb", 32'(sb.size()), 32'd0);
        return;
      end
    end
    if (over) begin
      chk("over_err", 32'(load_error), 32'd1);
      chk("over_ready", 32'(rx_ready), 32'd0);
      chk("over_cpu_reset", 32'(cpu_reset), 32'd1);
      for (int j = 0; j < 4; j++) drive_byte(8'hA5 + 8'(j), 0);
      chk("over_err_hold", 32'(load_error), 32'd1);
      chk("over_done", 32'(load_done), 32'd0);
    end else begin
      ok = (cs == x);
      chk("fin_done", 32'(load_done), 32'(ok));
      chk("fin_err", 32'(load_error), 32'(!ok));
      chk("fin_cpu_reset", 32'(cpu_reset), 32'(!ok));
      chk("fin_ready", 32'(rx_ready), 32'd0);
    end
    @(posedge clk); #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] w1[$];
    logic [31:0] wr[$];
    logic [31:0] none[$];
    w1 = '{32'h8C010004, 32'h20420001};

    repeat (2) @(posedge clk);
    #1;
    pulse_reset();

    // Case 1: good two-word image, checksum E8.
    load_image(w1, 2, 8'hE8, 0, 0);
    pulse_reset();
    // Case 2: same image, bad checksum.
    load_image(w1, 2, 8'hE9, 0, 0);
    pulse_reset();
    // Case 3: oversize length 257.
    load_image(none, 257, -1, 0, 0);
    pulse_reset();
    // Case 4: empty image.
    load_image(none, 0, 8'h00, 0, 0);
    pulse_reset();
    // Case 5: case 1 with random valid gaps.
    load_image(w1, 2, 8'hE8, 3, 0);
    pulse_reset();
    // Case 6: reset after byte 6, then full replay.
    load_image(w1, 2, 8'hE8, 0, 6);
    load_image(w1, 2, 8'hE8, 0, 0);
    pulse_reset();
    // Boundary: N = MAX_WORDS with random words and gaps.
    for (int k = 0; k < MAXW; k++) wr.push_back($urandom);
    load_image(wr, MAXW, -1, 1, 0);
    pulse_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Upstream boot stage for the single-cycle MIPS core. Receives a program image as a byte stream (e.g. from a UART receiver), packs it into 32-bit words, and writes them sequentially into instruction memory starting at word address 0. It verifies a length header and an XOR checksum, and holds the CPU in reset until the image is accepted. On a bad image it holds the CPU in reset permanently, until the next reset.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width. `MAX_WORDS = 2**ADDR_W`.
- `clk` in 1: the single clock. All state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: the loader accepts a byte. A byte transfers on a cycle with `rx_valid & rx_ready`.
- `imem_we` out 1: one-cycle instruction-memory write strobe.
- `imem_addr` out ADDR_W: word address of the write.
- `imem_wdata` out 32: word to write.
- `cpu_reset` out 1: drives the CPU `reset`. High in every state except RUN.
- `load_done` out 1: high in RUN.
- `load_error` out 1: high in ERROR.

## Operation
- Image format: LEN_HI, LEN_LO (16-bit big-endian word count N), then N words of 4 bytes each, most-significant byte first, then one CSUM byte.
- CSUM equals the XOR of every preceding byte, including both length bytes.
- States:
  - LEN_HI: on accept, goes to LEN_LO.
  - LEN_LO: on accept, computes N.
    - N > MAX_WORDS: goes to ERROR.
    - N = 0: goes to CSUM.
    - Otherwise: goes to DATA.
  - DATA: accepts 4·N bytes, then goes to CSUM.
  - CSUM: on accept, goes to RUN if the byte equals the running XOR, else to ERROR.
  - RUN: terminal until reset.
  - ERROR: terminal until reset.
- `rx_ready` = 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 in RUN and ERROR. It is a pure state decode; the loader never stalls the stream.
- Word packing: shift register, `{w[23:0], rx_data}`, plus a 2-bit byte counter.
- Word counter: word address k increments after each write and wraps only via reset. k never exceeds N−1, because N ≤ MAX_WORDS.
- The running XOR accumulates over every accepted byte except CSUM itself.
- Words already written before an ERROR stay in memory; ERROR only blocks CPU release.
- Reset at any point returns the loader to LEN_HI and clears the counters, XOR and shift register. Memory contents are untouched.

## Timing
- Reset values: `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_reset`=1, `load_done`=0, `load_error`=0, state LEN_HI. Hence `rx_ready`=1 from the first cycle after reset deasserts.
- Write latency: when the 4th byte of word k is accepted at edge E, then in the cycle after E:
  - `imem_we`=1, `imem_addr`=k, `imem_wdata`=assembled word.
  - The strobe is registered and lasts exactly one cycle.
  - `imem_addr` and `imem_wdata` hold their values until the next write.
- Back-to-back bytes on consecutive cycles are legal. Gaps with `rx_valid`=0 do not disturb state.
- A CSUM match accepted at edge E puts the loader in RUN after E: `cpu_reset` falls and `load_done` rises in the same cycle.
- The last word write occurs no later than the CSUM accept edge. Even with the fastest stream, the final `imem_we` precedes `cpu_reset` deassertion.
- An oversize length is flagged at the LEN_LO accept edge: `load_error`=1 and `rx_ready`=0 from the next cycle.
- `reset` has priority over any simultaneous byte transfer.

## Structure
- A shared package/include holds the state encoding localparams (LEN_HI, LEN_LO, DATA, CSUM, RUN, ERROR; 3 bits) and the image-format byte order constant.
- One sub-module, `byte_word_packer`: shift register plus byte counter, emitting `word_valid`/`word`. The FSM, address counter, XOR and output registers stay in the top-level module.
- The top level of the system instantiates the loader beside instruction memory, with `cpu_reset` driving the core's `reset`.

## Test plan
- Stream 00 02 8C 01 00 04 20 42 00 01 E8 back-to-back: writes addr0=0x8C010004 and addr1=0x20420001, each `imem_we` one cycle after its 4th byte; then `load_done`=1, `cpu_reset`=0.
- Same stream with CSUM E9: both writes occur, then `load_error`=1, `cpu_reset` stays 1, `rx_ready`=0.
- `ADDR_W`=8, stream 01 01 (N=257): ERROR immediately after LEN_LO, no `imem_we`, further bytes refused.
- Stream 00 00 00 (N=0, CSUM 00): RUN, with no `imem_we` ever asserted.
- Case 1 with random 0–3 cycle `rx_valid` gaps: identical writes and final state, write latency still one cycle.
- Case 1 with `reset` pulsed after byte 6: `cpu_reset` stays 1 and the state returns to LEN_HI. Replaying the full stream then yields the same result as case 1.
